// File: rtl/latency_pkg.sv
// latency_pkg: shared FSM encoding and width helper for the latency pipe
package latency_pkg;
  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/latency_pipe_ctrl_if.sv
// latency_pipe_ctrl_if: data/config/status bundle of the programmable delay line
interface latency_pipe_ctrl_if
  import latency_pkg::*;
#(
  parameter int MAX_LAT = 8,
  parameter int DSIZE   = 1
);
  localparam int LW = clog2(MAX_LAT + 1);
  logic             ce;
  logic             lat_load;
  logic [LW-1:0]    lat_cfg;
  logic [DSIZE-1:0] d;
  logic             d_valid;
  logic [DSIZE-1:0] q;
  logic             q_valid;
  logic [LW-1:0]    cur_lat;
  logic             primed;
  logic             cfg_err;
  modport master (
    output ce, lat_load, lat_cfg, d, d_valid,
    input  q, q_valid, cur_lat, primed, cfg_err
  );
  modport slave (
    input  ce, lat_load, lat_cfg, d, d_valid,
    output q, q_valid, cur_lat, primed, cfg_err
  );
endinterface

// File: rtl/latency_tap_mux.sv
// latency_tap_mux: picks stage sel-1 of the delay line, or the bypass input when sel is 0
module latency_tap_mux
  import latency_pkg::*;
#(
  parameter int MAX_LAT = 8,
  parameter int DSIZE   = 1,
  localparam int LW     = clog2(MAX_LAT + 1)
) (
  input  logic [LW-1:0]                   sel,
  input  logic [MAX_LAT-1:0]              sv,
  input  logic [MAX_LAT-1:0][DSIZE-1:0]   sd,
  input  logic                            byp_v,
  input  logic [DSIZE-1:0]                byp_d,
  output logic                            q_valid,
  output logic [DSIZE-1:0]                q
);
  always_comb begin
    q_valid = byp_v;
    q       = byp_d;
    for (int i = 0; i < MAX_LAT; i++)
      if (sel == LW'(i + 1)) begin
        q_valid = sv[i];
        q       = sd[i];
      end
  end
endmodule

// File: rtl/latency_pipe_ctrl.sv
// latency_pipe_ctrl: runtime-programmable valid/data delay line with fill FSM; LATENCY_PIPE_CTRL_OREG_EN adds an output register
module latency_pipe_ctrl
  import latency_pkg::*;
#(
  parameter int MAX_LAT = 8,
  parameter int DSIZE   = 1,
  parameter int RST_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  latency_pipe_ctrl_if.slave bus
);
  localparam int LW = clog2(MAX_LAT + 1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LAT);
  localparam logic [LW-1:0] RST_L = LW'(RST_LAT);
  typedef struct packed {
    logic             valid;
    logic [DSIZE-1:0] data;
  } stage_t;
  stage_t                        st [MAX_LAT];
  logic [MAX_LAT-1:0]            sv;
  logic [MAX_LAT-1:0][DSIZE-1:0] sd;
  logic [LW-1:0]                 cur_lat, fill_cnt, fill_cnt_n;
  state_e                        state, state_n;
  logic                          cfg_err, fill_done, tap_v;
  logic [DSIZE-1:0]              tap_d;
  // a reload clears only valid bits, so stale data may linger but never reads as valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAT; i++) st[i] <= '0;
      cur_lat <= RST_L;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bus.lat_load && (bus.lat_cfg > MAX_L);
      if (bus.lat_load) begin
        cur_lat <= (bus.lat_cfg > MAX_L) ? MAX_L : bus.lat_cfg;
        for (int i = 0; i < MAX_LAT; i++) st[i].valid <= 1'b0;
      end else if (bus.ce) begin
        st[0] <= {bus.d_valid, bus.d};
        for (int i = 1; i < MAX_LAT; i++) st[i] <= st[i-1];
      end
    end
  end
  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) begin
      sv[i] = st[i].valid;
      sd[i] = st[i].data;
    end
  end
  latency_tap_mux #(.MAX_LAT(MAX_LAT), .DSIZE(DSIZE)) u_tap (
    .sel    (cur_lat),
    .sv     (sv),
    .sd     (sd),
    .byp_v  (bus.d_valid),
    .byp_d  (bus.d),
    .q_valid(tap_v),
    .q      (tap_d)
  );
`ifdef LATENCY_PIPE_CTRL_OREG_EN
  logic             oq_v;
  logic [DSIZE-1:0] oq_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      oq_v <= 1'b0;
      oq_d <= '0;
    end else if (bus.lat_load) begin
      oq_v <= 1'b0;
    end else if (bus.ce) begin
      oq_v <= tap_v;
      oq_d <= tap_d;
    end
  end
  assign bus.q       = oq_d;
  assign bus.q_valid = oq_v;
  // the output register adds one ce edge to the fill, including at latency 0
  assign fill_done   = bus.ce && (fill_cnt == cur_lat);
`else
  assign bus.q       = tap_d;
  assign bus.q_valid = tap_v;
  assign fill_done   = (cur_lat == '0) || (bus.ce && (fill_cnt == cur_lat - LW'(1)));
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_cnt_n;
    end
  end
  always_comb begin
    state_n    = state;
    fill_cnt_n = fill_cnt;
    if (bus.lat_load) begin
      state_n    = ST_FILL;
      fill_cnt_n = '0;
    end else if (state == ST_FILL && fill_done) begin
      state_n = ST_RUN;
    end else if (state == ST_FILL && bus.ce) begin
      fill_cnt_n = (&fill_cnt) ? fill_cnt : fill_cnt + LW'(1);
    end
  end
  assign bus.cur_lat = cur_lat;
  assign bus.primed  = (state == ST_RUN);
  assign bus.cfg_err = cfg_err;
endmodule
